// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator for the word-addressed data memory
//
// Purpose: accepts one pipeline load/store request at a time and drives the data
// memory. It handles byte/half/word sizing, little-endian lane select, sign or zero
// extension of loads, read-modify-write for sub-word stores, and exception reporting.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_we, req_size,        request fields: store flag, size (00 b, 01 h, 1x w),
//   req_signed, req_addr,    load extension, byte address, right-justified store
//   req_wdata, exception_in  data, upstream exception (nonzero suppresses access)
//   resp_valid               one-cycle completion pulse
//   resp_rdata, exception    load result (0 for stores) and final exception code
//   dm_addr, dm_din, dm_we   memory address, write data, write strobe
//   dm_dout                  combinational memory read data
//
// Build option: define MAU_UNALIGNED_TRAP_EN to trap misaligned accesses with
// EXC_ADEL/EXC_ADES; otherwise misaligned addresses are forced to alignment.

`ifndef TRAP_STALL
`define TRAP_STALL 8'h01
`endif

module mem_access_unit #(
    parameter int          ADDR_W   = 12,
    parameter logic [7:0]  EXC_ADEL = 8'h04,
    parameter logic [7:0]  EXC_ADES = 8'h05
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [7:0]        exception_in,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [7:0]        exception,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;

    state_t            state, state_next;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              trap;
    logic [ADDR_W-1:0] addr_eff;
    logic [31:0]       load_ext;
    logic [31:0]       merged;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

`ifdef MAU_UNALIGNED_TRAP_EN
    always_comb begin
        trap     = req_size[1] ? (req_addr[1:0] != 2'b00)
                 : (req_size == 2'b01) ? req_addr[0] : 1'b0;
        addr_eff = req_addr;
    end
`else
    always_comb begin
        trap     = 1'b0;
        addr_eff = req_addr;
        if (req_size[1])
            addr_eff[1:0] = 2'b00;
        else if (req_size == 2'b01)
            addr_eff[0] = 1'b0;
    end
`endif

    assign req_ready = (state == IDLE);

    // Write strobe is combinational so a reset in the same cycle kills the write.
    assign dm_we = ~rst & (((state == ACCESS) && we_q && size_q[1]) || (state == WRITE));

    // Lane extraction and sub-word merge both key off the latched (aligned) address.
    always_comb begin
        byte_sel = dm_dout[{dm_addr[1:0], 3'b000} +: 8];
        half_sel = dm_addr[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_ext = dm_dout;
        endcase
        merged = dm_dout;
        if (size_q == 2'b00)
            merged[{dm_addr[1:0], 3'b000} +: 8] = dm_din[7:0];
        else
            merged[{dm_addr[1], 4'b0000} +: 16] = dm_din[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:
                if (req_valid && (exception_in == 8'h00) && !trap)
                    state_next = ACCESS;
            ACCESS:
                state_next = (we_q && !size_q[1]) ? WRITE : IDLE;
            WRITE:
                state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    // dm_din doubles as the store-data latch and, for sub-word stores, the merge register.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            exception  <= `TRAP_STALL;
            dm_addr    <= '0;
            dm_din     <= 32'h0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        dm_addr  <= addr_eff;
                        dm_din   <= req_wdata;
                        we_q     <= req_we;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        if (exception_in != 8'h00) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            exception  <= exception_in;
                        end else if (trap) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            exception  <= req_we ? EXC_ADES : EXC_ADEL;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_ext;
                        exception  <= 8'h00;
                    end else if (size_q[1]) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'h0;
                        exception  <= 8'h00;
                    end else begin
                        dm_din <= merged;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                    exception  <= 8'h00;
                end
                default: ;
            endcase
        end
    end

endmodule
